// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter: round-robin grant, bus locked for the owner's whole cyc.
// Define ARB_TIMEOUT_EN to add the slave-ack watchdog that errors stalled accesses.
`timescale 1ns/1ps

module wb_arbiter2 #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       m0_cyc_i,
  input  logic       m0_stb_i,
  input  logic       m0_we_i,
  input  logic [7:0] m0_adr_i,
  input  logic [7:0] m0_dat_i,
  output logic [7:0] m0_dat_o,
  output logic       m0_ack_o,
  output logic       m0_err_o,
  input  logic       m1_cyc_i,
  input  logic       m1_stb_i,
  input  logic       m1_we_i,
  input  logic [7:0] m1_adr_i,
  input  logic [7:0] m1_dat_i,
  output logic [7:0] m1_dat_o,
  output logic       m1_ack_o,
  output logic       m1_err_o,
  output logic       s_cyc_o,
  output logic       s_stb_o,
  output logic       s_we_o,
  output logic [7:0] s_adr_o,
  output logic [7:0] s_dat_o,
  input  logic [7:0] s_dat_i,
  input  logic       s_ack_i,
  output logic [1:0] gnt_o
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << CNT_W)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_gnt_q, last_gnt_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_gnt_q ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_d = GNT0;
        else if (m1_cyc_i)        state_d = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          last_gnt_d = 1'b0;
          state_d    = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          last_gnt_d = 1'b1;
          state_d    = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_o = {state_q == GNT1, state_q == GNT0};

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (state_q == GNT0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (state_q == GNT1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  // Read data is broadcast; only the owner's ack qualifies it.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & gnt_o[0];
  assign m1_ack_o = s_ack_i & gnt_o[1];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             stall;
  logic             expire;

  assign stall  = s_cyc_o & s_stb_o & ~s_ack_i;
  assign expire = stall && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter holds while the owner idles its strobe without an ack.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                            cnt_q <= '0;
    else if (state_q == IDLE || state_d != state_q || s_ack_i || expire) cnt_q <= '0;
    else if (stall)                                         cnt_q <= cnt_q + CNT_W'(1);
  end

  assign m0_err_o = expire & gnt_o[0];
  assign m1_err_o = expire & gnt_o[1];
`else
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: vector table, corner-case sequences, and
// randomized traffic against a transaction-level ownership model.
`timescale 1ns/1ps

module tb_wb_arbiter2;
  localparam int TIMEOUT = 16;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       m0_cyc_i, m0_stb_i, m0_we_i;
  logic [7:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic       m0_ack_o, m0_err_o;
  logic       m1_cyc_i, m1_stb_i, m1_we_i;
  logic [7:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic       m1_ack_o, m1_err_o;
  logic       s_cyc_o, s_stb_o, s_we_o;
  logic [7:0] s_adr_o, s_dat_o, s_dat_i;
  logic       s_ack_i;
  logic [1:0] gnt_o;

  logic       ack_en;
  logic [7:0] mem [256];

  int checks = 0;
  int failures = 0;

  int owner;
  int last_owner;
  int run;

  wb_arbiter2 #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory slave: same-cycle ack when enabled, preset contents i ^ 0x1C.
  assign s_ack_i = ack_en & s_cyc_o & s_stb_o;
  assign s_dat_i = mem[s_adr_o];

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h1C;
    end else if (s_ack_i && s_we_o) begin
      mem[s_adr_o] <= s_dat_o;
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_m0(input logic c, input logic s, input logic w,
                        input logic [7:0] a, input logic [7:0] d);
    m0_cyc_i = c; m0_stb_i = s; m0_we_i = w; m0_adr_i = a; m0_dat_i = d;
  endtask

  task automatic set_m1(input logic c, input logic s, input logic w,
                        input logic [7:0] a, input logic [7:0] d);
    m1_cyc_i = c; m1_stb_i = s; m1_we_i = w; m1_adr_i = a; m1_dat_i = d;
  endtask

  function automatic logic cyc_of(input int n);
    return (n == 0) ? m0_cyc_i : m1_cyc_i;
  endfunction

  // Round-robin with lock: owner keeps the bus until it drops cyc.
  function automatic int next_owner();
    if (owner < 0) begin
      if (m0_cyc_i && m1_cyc_i) return 1 - last_owner;
      if (m0_cyc_i) return 0;
      if (m1_cyc_i) return 1;
      return -1;
    end
    if (cyc_of(owner)) return owner;
    if (cyc_of(1 - owner)) return 1 - owner;
    return -1;
  endfunction

  task automatic bus_exp(output logic c, output logic s, output logic w,
                         output logic [7:0] a, output logic [7:0] d);
    {c, s, w, a, d} = '0;
    if (owner == 0)      {c, s, w, a, d} = {m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i};
    else if (owner == 1) {c, s, w, a, d} = {m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i};
  endtask

  task automatic step();
    logic c, s, w;
    logic [7:0] a, d;
    int nxt;
    bus_exp(c, s, w, a, d);
    nxt = next_owner();
    if (owner >= 0 && nxt != owner) last_owner = owner;
    if (owner < 0 || nxt != owner) run = 0;
    else if (c && s && ack_en)     run = 0;
    else if (c && s)               run = (run == TIMEOUT - 1) ? 0 : run + 1;
    owner = nxt;
    @(posedge clk_i);
    #2;
  endtask

  task automatic model_reset();
    owner = -1;
    last_owner = 1;
    run = 0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    set_m0(0, 0, 0, 8'h00, 8'h00);
    set_m1(0, 0, 0, 8'h00, 8'h00);
    ack_en = 1'b1;
    repeat (2) @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    model_reset();
  endtask

  function automatic logic [1:0] owner_gnt();
    return (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
  endfunction

  typedef struct {
    logic       m0_cyc, m0_stb, m0_we;
    logic [7:0] m0_adr, m0_dat;
    logic       m1_cyc, m1_stb, m1_we;
    logic [7:0] m1_adr, m1_dat;
    logic       ack;
    logic [1:0] gnt;
    logic [7:0] adr, dat;
    logic       m0_ack, m1_ack;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int grants [$];
    int acks_wrong;
    int m1_acks;
    int err_cnt, err_at, ack_cnt;
    logic c, s, w, sa, e0, e1;
    logic [7:0] a, d;

    vecs[0] = '{1,1,1,8'h10,8'hA5, 0,0,0,8'h00,8'h00, 1, 2'b01,8'h10,8'hA5,1,0};
    vecs[1] = '{1,1,0,8'h11,8'h00, 0,0,0,8'h00,8'h00, 0, 2'b01,8'h11,8'h00,0,0};
    vecs[2] = '{0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 1, 2'b00,8'h00,8'h00,0,0};
    vecs[3] = '{1,1,0,8'h30,8'h00, 1,1,1,8'h20,8'h77, 1, 2'b10,8'h20,8'h77,0,1};
    vecs[4] = '{1,1,0,8'h30,8'h11, 0,0,0,8'h00,8'h00, 1, 2'b01,8'h30,8'h11,1,0};
    vecs[5] = '{1,0,0,8'h31,8'h22, 1,1,1,8'h44,8'h99, 1, 2'b01,8'h31,8'h22,0,0};
    vecs[6] = '{0,0,0,8'h00,8'h00, 1,1,0,8'h44,8'h00, 1, 2'b10,8'h44,8'h00,0,1};
    vecs[7] = '{0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 1, 2'b00,8'h00,8'h00,0,0};

    // Reset state with active requests: nothing may leak through.
    rst_ni = 1'b0;
    set_m0(1, 1, 1, 8'hFF, 8'hEE);
    set_m1(1, 1, 1, 8'hDD, 8'hCC);
    ack_en = 1'b1;
    #3;
    check("reset_gnt", gnt_o, 2'b00);
    check("reset_bus", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o}, '0);
    check("reset_resp", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, '0);

    // Vector table.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_m0(vecs[i].m0_cyc, vecs[i].m0_stb, vecs[i].m0_we, vecs[i].m0_adr, vecs[i].m0_dat);
      set_m1(vecs[i].m1_cyc, vecs[i].m1_stb, vecs[i].m1_we, vecs[i].m1_adr, vecs[i].m1_dat);
      ack_en = vecs[i].ack;
      step();
      check($sformatf("vec%0d_gnt", i), gnt_o, vecs[i].gnt);
      check($sformatf("vec%0d_adr", i), s_adr_o, vecs[i].adr);
      check($sformatf("vec%0d_dat", i), s_dat_o, vecs[i].dat);
      check($sformatf("vec%0d_m0_ack", i), m0_ack_o, vecs[i].m0_ack);
      check($sformatf("vec%0d_m1_ack", i), m1_ack_o, vecs[i].m1_ack);
    end

    // Simultaneous request after reset, then handover without an IDLE bubble.
    do_reset();
    set_m0(1, 1, 0, 8'h05, 8'h00);
    set_m1(1, 1, 0, 8'h20, 8'h00);
    step();
    check("tie_gnt0", gnt_o, 2'b01);
    check("tie_m1_no_ack", m1_ack_o, 1'b0);
    set_m0(0, 0, 0, 8'h00, 8'h00);
    step();
    check("handover_gnt1", gnt_o, 2'b10);
    check("handover_m1_dat", m1_dat_o, 8'h3C);
    check("handover_m1_ack", m1_ack_o, 1'b1);

    // Continuous single accesses from both masters alternate the grant.
    do_reset();
    set_m0(1, 1, 0, 8'h01, 8'h00);
    set_m1(1, 1, 0, 8'h02, 8'h00);
    acks_wrong = 0;
    for (int cyc = 0; cyc < 40 && grants.size() < 6; cyc++) begin
      step();
      if (gnt_o == 2'b01) grants.push_back(0);
      if (gnt_o == 2'b10) grants.push_back(1);
      if ((m0_ack_o && !gnt_o[0]) || (m1_ack_o && !gnt_o[1])) acks_wrong++;
      m0_cyc_i = !m0_ack_o; m0_stb_i = !m0_ack_o;
      m1_cyc_i = !m1_ack_o; m1_stb_i = !m1_ack_o;
    end
    check("alt_count", grants.size(), 6);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      check($sformatf("alt_grant%0d", i), grants[i], i % 2);
    check("alt_no_stray_ack", acks_wrong, 0);

    // Four-access burst by m1 while m0 waits.
    do_reset();
    set_m1(1, 1, 0, 8'h40, 8'h00);
    step();
    set_m0(1, 1, 0, 8'h50, 8'h00);
    m1_acks = 0;
    acks_wrong = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        m1_adr_i = 8'(8'h40 + i);
        step();
      end
      if (gnt_o != 2'b10 || m0_ack_o) acks_wrong++;
      if (m1_ack_o) m1_acks++;
    end
    check("burst_m1_acks", m1_acks, 4);
    check("burst_locked", acks_wrong, 0);
    set_m1(0, 0, 0, 8'h00, 8'h00);
    step();
    check("burst_release_gnt0", gnt_o, 2'b01);

    // Asynchronous reset in the middle of a GNT1 transfer.
    do_reset();
    set_m1(1, 1, 1, 8'h60, 8'h12);
    step();
    check("pre_reset_gnt1", gnt_o, 2'b10);
    #1;
    rst_ni = 1'b0;
    #1;
    check("async_reset_gnt", gnt_o, 2'b00);
    check("async_reset_cyc", s_cyc_o, 1'b0);
    set_m1(0, 0, 0, 8'h00, 8'h00);
    set_m0(1, 1, 0, 8'h70, 8'h00);
    #3;
    rst_ni = 1'b1;
    model_reset();
    step();
    check("post_reset_gnt0", gnt_o, 2'b01);

    // Stalled slave: watchdog behaviour.
    do_reset();
    ack_en = 1'b0;
    set_m0(1, 1, 0, 8'h08, 8'h00);
    err_cnt = 0;
    err_at = -1;
    ack_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (m0_err_o) begin
        err_cnt++;
        if (err_at < 0) err_at = i;
      end
      if (m0_ack_o || m1_err_o) ack_cnt++;
    end
    check("stall_no_ack", ack_cnt, 0);
    check("stall_still_gnt0", gnt_o, 2'b01);
`ifdef ARB_TIMEOUT_EN
    check("timeout_pulses", err_cnt, 1);
    check("timeout_cycle", err_at, TIMEOUT);
`else
    check("no_timeout_err", err_cnt, 0);
`endif

    // Randomized traffic against the ownership model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_m0($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      set_m1($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      ack_en = $urandom_range(0, 3) != 0;
      step();
      bus_exp(c, s, w, a, d);
      sa = ack_en & c & s;
`ifdef ARB_TIMEOUT_EN
      e0 = c && s && !ack_en && run == TIMEOUT - 1 && owner == 0;
      e1 = c && s && !ack_en && run == TIMEOUT - 1 && owner == 1;
`else
      e0 = 1'b0;
      e1 = 1'b0;
`endif
      check($sformatf("random%0d", i),
            {gnt_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
             m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o, m0_err_o, m1_err_o},
            {owner_gnt(), c, s, w, a, d,
             sa && owner == 0, sa && owner == 1, mem[a], mem[a], e0, e1});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master Wishbone arbiter that shares the single 8-bit data memory slave between the controller core (master 0) and the sensor-logging DMA engine (master 1).
- Performs round-robin arbitration with bus lock for the full duration of a master's cyc.
- Routes handshakes and data between the granted master and the memory; the other master sees no ack.
- Sits directly in front of the data memory in the controller subsystem.

Parameters:
- TIMEOUT_CYCLES, 16: cycles a strobed slave access may wait for ack before the watchdog errors it (used only with ARB_TIMEOUT_EN).
- CNT_W, 5: width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone controls.
- m0_adr_i  in  8  master 0 address.
- m0_dat_i  in  8  master 0 write data.
- m0_dat_o  out  8  master 0 read data.
- m0_ack_o  out  1  master 0 acknowledge.
- m0_err_o  out  1  master 0 error (timeout).
- m1_*: same set as m0_* for master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  controls to memory.
- s_adr_o  out  8  address to memory.
- s_dat_o  out  8  write data to memory.
- s_dat_i  in  8  read data from memory.
- s_ack_i  in  1  memory acknowledge.
- gnt_o  out  2  one-hot grant status; bit n means master n owns the bus.

Behaviour:
- Interface is fixed: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values:
  - State is IDLE and gnt_o=00.
  - last_gnt=1, so master 0 wins the first tie.
  - Watchdog counter is 0.
  - s_cyc_o, s_stb_o, s_we_o, m*_ack_o and m*_err_o are all 0.
  - s_adr_o and s_dat_o are 00.
- Reset asserted mid-transfer forces IDLE immediately. Nothing pending is retained.
- States: IDLE, GNT0, GNT1. The state is registered and gnt_o decodes directly from it.
- IDLE:
  - Only m0_cyc_i → GNT0. Only m1_cyc_i → GNT1.
  - Both asserted → grant the master opposite last_gnt.
  - Neither asserted → stay in IDLE.
- Arbitration latency: one cycle from cyc rise to grant. Slave signals become visible the cycle the state is GNTn.
- GNTn:
  - Hold while mn_cyc_i=1. Bursts and consecutive stb accesses under one cyc are never interrupted.
  - On mn_cyc_i=0, set last_gnt=n.
  - If the other master has cyc asserted, go directly to its GNT state (no IDLE bubble). Otherwise go to IDLE.
- Muxing is combinational from the registered state:
  - In GNTn: s_cyc_o=mn_cyc_i, s_stb_o=mn_stb_i, s_we_o=mn_we_i, s_adr_o=mn_adr_i, s_dat_o=mn_dat_i.
  - In IDLE: s_cyc_o=s_stb_o=s_we_o=0; address and data are driven 00.
- Return path:
  - mn_ack_o = s_ack_i & gnt_o[n].
  - m0_dat_o and m1_dat_o both carry s_dat_i; only the granted master sees ack.
- Slave ack may be same-cycle (combinational) or registered; the arbiter adds no latency to either.
- A non-granted master's strobe is ignored: no ack and no side effects. That master simply waits.
- Simultaneous release by the owner and request by the other in the same cycle: handover occurs on the next edge.
- Both masters requesting continuously with single-access cycles: grants alternate 0,1,0,1…

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - The counter increments each cycle s_cyc_o & s_stb_o & ~s_ack_i, and clears on ack, on grant change, or in IDLE.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack, mn_err_o pulses for one cycle to the granted master and the counter clears.
  - The grant is kept until that master drops cyc.
  - err and ack are never asserted together; an ack arriving in the timeout cycle wins.
- Undefined: no counter logic; m0_err_o=m1_err_o=0 constantly.

Test Plan:
- Reset, then m0 cyc/stb/we=1, adr=0x10, dat=0xA5 → gnt_o=01 one cycle later; s_adr_o=0x10, s_dat_o=0xA5; m0_ack_o follows s_ack_i; m1_ack_o=0.
- m0 and m1 assert cyc in the same cycle after reset → GNT0 first. m0 drops cyc → gnt_o=10 on the next edge with no IDLE cycle. m1 reads adr=0x20, memory returns 0x3C → m1_dat_o=0x3C with m1_ack_o=1.
- Both masters issue back-to-back single reads continuously for 6 transfers → grant sequence 0,1,0,1,0,1; no master is acked while not granted.
- m1 holds cyc for a 4-access burst while m0 requests → m1 keeps the grant for all 4 acks; m0 is granted the cycle after m1 drops cyc.
- rst_ni pulled low mid-transfer while in GNT1 → gnt_o=00 and s_cyc_o=0 immediately, asynchronously. After release with only m0 requesting → GNT0.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, m0 strobes and s_ack_i is held 0 → m0_err_o=1 for exactly 1 cycle after 16 stalled cycles. m0_ack_o stays 0. Without the macro, m0_err_o remains 0.
